pixel_readout_ctrl: RTL and testbench



---
 rtl/pixel_ctrl_pkg.sv | 39 +++
 rtl/pixel_readout_ctrl_phase_timer.sv | 45 ++++
 rtl/pixel_readout_ctrl.sv | 279 +++++++++++++++++++++++++++
 tb/tb_pixel_readout_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_ctrl_pkg.sv
// Shared definitions for the pixel readout controller: frame state encoding,
// data widths, and the Gray-code conversion helpers used on the count bus.
package pixel_ctrl_pkg;

  localparam int CNT_W       = 8;
  localparam int PIX_PER_ROW = 2;
  // Phase timer width: must hold the largest phase length (256 count steps).
  localparam int TMR_W       = 9;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    ERASE      = 4'd1,
    EXPOSE     = 4'd2,
    CONVERT    = 4'd3,
    RD1_SETTLE = 4'd4,
    RD1_OUT    = 4'd5,
    RD2_SETTLE = 4'd6,
    RD2_OUT    = 4'd7,
    DONE       = 4'd8
  } state_e;

  // Binary to reflected Gray code.
  function automatic logic [CNT_W-1:0] gray_enc(input logic [CNT_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Reflected Gray code back to binary: each bit is the XOR of all higher Gray bits.
  function automatic logic [CNT_W-1:0] gray_dec(input logic [CNT_W-1:0] gray);
    logic [CNT_W-1:0] bin;
    bin[CNT_W-1] = gray[CNT_W-1];
    for (int i = CNT_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/pixel_readout_ctrl_phase_timer.sv
// Loadable down-counter shared by every timed phase of the frame. Loading N
// makes tc_o high on the N-th cycle after the load edge, i.e. on the last
// cycle of an N-cycle phase that starts on that edge.
module phase_timer
  import pixel_ctrl_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         tc_q;

  // Next count: reload, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {W{1'b0}}) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register and registered terminal-count flag (high while count is 1).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= {W{1'b0}};
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= (cnt_d == {{(W-1){1'b0}}, 1'b1});
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/pixel_readout_ctrl.sv
// Frame controller for the 2x2 pixel array: erase, expose, ramp conversion
// with a count driven onto the pixel buses, then row-by-row capture and a
// valid/ready pixel stream toward the frame buffer.
// Build option: define GRAY_COUNT_EN to put Gray code on cnt_bus and decode
// captured values back to binary before px_data.
module pixel_readout_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int unsigned ERASE_CYCLES  = 5,
  parameter int unsigned EXPOSE_CYCLES = 10,
  parameter int unsigned CONV_CYCLES   = 256,
  parameter int unsigned READ_SETTLE   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             erase,
  output logic             expose,
  output logic             convert,
  output logic             read1,
  output logic             read2,
  output logic [CNT_W-1:0] cnt_bus,
  output logic             cnt_oe,
  input  logic [15:0]      pix_in,
  output logic             px_valid,
  input  logic             px_ready,
  output logic [CNT_W-1:0] px_data,
  output logic [1:0]       px_idx,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [TMR_W-1:0] ERASE_LD  = TMR_W'(ERASE_CYCLES);
  localparam logic [TMR_W-1:0] EXPOSE_LD = TMR_W'(EXPOSE_CYCLES);
  localparam logic [TMR_W-1:0] CONV_LD   = TMR_W'(CONV_CYCLES);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(READ_SETTLE);

`ifdef GRAY_COUNT_EN
  function automatic logic [CNT_W-1:0] bus_enc(input logic [CNT_W-1:0] bin);
    return gray_enc(bin);
  endfunction
  function automatic logic [CNT_W-1:0] pix_dec(input logic [CNT_W-1:0] raw);
    return gray_dec(raw);
  endfunction
`else
  function automatic logic [CNT_W-1:0] bus_enc(input logic [CNT_W-1:0] bin);
    return bin;
  endfunction
  function automatic logic [CNT_W-1:0] pix_dec(input logic [CNT_W-1:0] raw);
    return raw;
  endfunction
`endif

  state_e           state_q;
  logic [CNT_W-1:0] bin_q;
  logic [CNT_W-1:0] buf_q [PIX_PER_ROW];

  logic             erase_q;
  logic             expose_q;
  logic             convert_q;
  logic             read1_q;
  logic             read2_q;
  logic [CNT_W-1:0] cnt_bus_q;
  logic             cnt_oe_q;
  logic             px_valid_q;
  logic [CNT_W-1:0] px_data_q;
  logic [1:0]       px_idx_q;
  logic             busy_q;
  logic             frame_done_q;

  logic             tmr_load_d;
  logic [TMR_W-1:0] tmr_val_d;
  logic             tmr_tc_s;
  logic             xfer_s;
  logic             col_nxt_s;

  assign xfer_s    = px_valid_q & px_ready;
  // Column of the pixel that follows the one currently presented.
  assign col_nxt_s = ~px_idx_q[0];

  // Timer reload on every edge that enters a timed phase.
  always_comb begin
    tmr_load_d = 1'b0;
    tmr_val_d  = {TMR_W{1'b0}};
    case (state_q)
      IDLE: begin
        if (start) begin
          tmr_load_d = 1'b1;
          tmr_val_d  = ERASE_LD;
        end else begin
          tmr_load_d = 1'b0;
        end
      end
      ERASE: begin
        if (tmr_tc_s) begin
          tmr_load_d = 1'b1;
          tmr_val_d  = EXPOSE_LD;
        end else begin
          tmr_load_d = 1'b0;
        end
      end
      EXPOSE: begin
        if (tmr_tc_s) begin
          tmr_load_d = 1'b1;
          tmr_val_d  = CONV_LD;
        end else begin
          tmr_load_d = 1'b0;
        end
      end
      CONVERT: begin
        if (tmr_tc_s) begin
          tmr_load_d = 1'b1;
          tmr_val_d  = SETTLE_LD;
        end else begin
          tmr_load_d = 1'b0;
        end
      end
      RD1_OUT: begin
        if (xfer_s && px_idx_q[0]) begin
          tmr_load_d = 1'b1;
          tmr_val_d  = SETTLE_LD;
        end else begin
          tmr_load_d = 1'b0;
        end
      end
      default: begin
        tmr_load_d = 1'b0;
      end
    endcase
  end

  phase_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (tmr_load_d),
    .load_val_i (tmr_val_d),
    .tc_o       (tmr_tc_s)
  );

  // Frame FSM with all array control and stream outputs registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      bin_q        <= {CNT_W{1'b0}};
      for (int i = 0; i < PIX_PER_ROW; i++) begin
        buf_q[i] <= {CNT_W{1'b0}};
      end
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      convert_q    <= 1'b0;
      read1_q      <= 1'b0;
      read2_q      <= 1'b0;
      cnt_bus_q    <= {CNT_W{1'b0}};
      cnt_oe_q     <= 1'b0;
      px_valid_q   <= 1'b0;
      px_data_q    <= {CNT_W{1'b0}};
      px_idx_q     <= 2'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ERASE;
            erase_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ERASE: begin
          if (tmr_tc_s) begin
            state_q  <= EXPOSE;
            erase_q  <= 1'b0;
            expose_q <= 1'b1;
          end
        end
        EXPOSE: begin
          if (tmr_tc_s) begin
            state_q   <= CONVERT;
            expose_q  <= 1'b0;
            convert_q <= 1'b1;
            cnt_oe_q  <= 1'b1;
            bin_q     <= {CNT_W{1'b0}};
            cnt_bus_q <= bus_enc({CNT_W{1'b0}});
          end
        end
        CONVERT: begin
          if (tmr_tc_s) begin
            // Release the buses before any read line goes high.
            state_q   <= RD1_SETTLE;
            convert_q <= 1'b0;
            cnt_oe_q  <= 1'b0;
            cnt_bus_q <= {CNT_W{1'b0}};
            read1_q   <= 1'b1;
          end else begin
            bin_q     <= bin_q + CNT_ONE;
            cnt_bus_q <= bus_enc(bin_q + CNT_ONE);
          end
        end
        RD1_SETTLE: begin
          if (tmr_tc_s) begin
            state_q    <= RD1_OUT;
            read1_q    <= 1'b0;
            buf_q[0]   <= pix_in[7:0];
            buf_q[1]   <= pix_in[15:8];
            px_valid_q <= 1'b1;
            px_idx_q   <= 2'd0;
            px_data_q  <= pix_dec(pix_in[7:0]);
          end
        end
        RD1_OUT: begin
          if (xfer_s) begin
            if (!px_idx_q[0]) begin
              px_idx_q  <= 2'd1;
              px_data_q <= pix_dec(buf_q[col_nxt_s]);
            end else begin
              state_q    <= RD2_SETTLE;
              px_valid_q <= 1'b0;
              read2_q    <= 1'b1;
            end
          end
        end
        RD2_SETTLE: begin
          if (tmr_tc_s) begin
            state_q    <= RD2_OUT;
            read2_q    <= 1'b0;
            buf_q[0]   <= pix_in[7:0];
            buf_q[1]   <= pix_in[15:8];
            px_valid_q <= 1'b1;
            px_idx_q   <= 2'd2;
            px_data_q  <= pix_dec(pix_in[7:0]);
          end
        end
        RD2_OUT: begin
          if (xfer_s) begin
            if (!px_idx_q[0]) begin
              px_idx_q  <= 2'd3;
              px_data_q <= pix_dec(buf_q[col_nxt_s]);
            end else begin
              state_q      <= DONE;
              px_valid_q   <= 1'b0;
              frame_done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          // Unreachable encoding: drop back to a quiet idle array.
          state_q    <= IDLE;
          erase_q    <= 1'b0;
          expose_q   <= 1'b0;
          convert_q  <= 1'b0;
          read1_q    <= 1'b0;
          read2_q    <= 1'b0;
          cnt_oe_q   <= 1'b0;
          px_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign erase      = erase_q;
  assign expose     = expose_q;
  assign convert    = convert_q;
  assign read1      = read1_q;
  assign read2      = read2_q;
  assign cnt_bus    = cnt_bus_q;
  assign cnt_oe     = cnt_oe_q;
  assign px_valid   = px_valid_q;
  assign px_data    = px_data_q;
  assign px_idx     = px_idx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Self-checking bench for pixel_readout_ctrl with default parameters.
// Cycle 0 is the cycle in which start is high; outputs are sampled 1 ns
// after each rising edge.
module tb_pixel_readout_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        erase, expose, convert, read1, read2;
  logic [7:0]  cnt_bus;
  logic        cnt_oe;
  logic [15:0] pix_in;
  logic        px_valid;
  logic        px_ready;
  logic [7:0]  px_data;
  logic [1:0]  px_idx;
  logic        busy;
  logic        frame_done;

  always #5 clk = ~clk;

`ifdef GRAY_COUNT_EN
  localparam logic [15:0] ROW1 = 16'h0C0C;
  localparam logic [15:0] ROW2 = 16'h0D07;
  localparam logic [7:0]  D0 = 8'h08, D1 = 8'h08, D2 = 8'h05, D3 = 8'h09;
  localparam logic [7:0]  BUS5 = 8'h07, BUS255 = 8'h80;
  function automatic logic [7:0] exp_bus(input int n);
    logic [7:0] b;
    b = n[7:0];
    return b ^ (b >> 1);
  endfunction
`else
  localparam logic [15:0] ROW1 = 16'h2010;
  localparam logic [15:0] ROW2 = 16'h4030;
  localparam logic [7:0]  D0 = 8'h10, D1 = 8'h20, D2 = 8'h30, D3 = 8'h40;
  localparam logic [7:0]  BUS5 = 8'h05, BUS255 = 8'hFF;
  function automatic logic [7:0] exp_bus(input int n);
    return n[7:0];
  endfunction
`endif

  // Pixel array model: the selected row drives its latched values back.
  always_comb begin
    if (read1) pix_in = ROW1;
    else if (read2) pix_in = ROW2;
    else pix_in = 16'h0000;
  end

  pixel_readout_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .erase(erase), .expose(expose), .convert(convert),
    .read1(read1), .read2(read2), .cnt_bus(cnt_bus), .cnt_oe(cnt_oe),
    .pix_in(pix_in), .px_valid(px_valid), .px_ready(px_ready),
    .px_data(px_data), .px_idx(px_idx), .busy(busy), .frame_done(frame_done)
  );

  typedef struct {
    int         cyc;
    logic [4:0] ph;    // {erase, expose, convert, read1, read2}
    logic       oe;
    logic [7:0] bus;
    logic       vld;
    logic [1:0] idx;
    logic [7:0] data;
    logic       bsy;
    logic       done;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    px_ready = 1'b1;
    step();
    step();
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] all_outs();
    return {erase, expose, convert, read1, read2, cnt_oe, cnt_bus,
            px_valid, px_data, px_idx, busy, frame_done};
  endfunction

  // One full frame from a start pulse, checked against the vector table and
  // swept for phase lengths, count sequence and exclusivity.
  task automatic run_nominal(input string tag);
    int k = 0;
    int n_er = 0, n_ex = 0, n_cv = 0, seq_err = 0, excl_err = 0, oe_err = 0;
    px_ready = 1'b1;
    start    = 1'b1;
    cyc      = 0;
    for (int c = 1; c <= 282; c++) begin
      step();
      start = 1'b0;
      n_er += int'(erase);
      n_ex += int'(expose);
      if (convert) begin
        if (cnt_bus !== exp_bus(n_cv)) seq_err++;
        n_cv++;
      end
      if ($countones({erase, expose, convert, read1, read2}) > 1) excl_err++;
      if (cnt_oe !== convert) oe_err++;
      if (k < NV && tbl[k].cyc == cyc) begin
        chk($sformatf("%s c%0d phase", tag, cyc), {27'd0, erase, expose, convert, read1, read2}, {27'd0, tbl[k].ph});
        chk($sformatf("%s c%0d cnt_oe", tag, cyc), {31'd0, cnt_oe}, {31'd0, tbl[k].oe});
        if (tbl[k].oe) chk($sformatf("%s c%0d cnt_bus", tag, cyc), {24'd0, cnt_bus}, {24'd0, tbl[k].bus});
        chk($sformatf("%s c%0d px_valid", tag, cyc), {31'd0, px_valid}, {31'd0, tbl[k].vld});
        if (tbl[k].vld) begin
          chk($sformatf("%s c%0d px_idx", tag, cyc), {30'd0, px_idx}, {30'd0, tbl[k].idx});
          chk($sformatf("%s c%0d px_data", tag, cyc), {24'd0, px_data}, {24'd0, tbl[k].data});
        end
        chk($sformatf("%s c%0d busy", tag, cyc), {31'd0, busy}, {31'd0, tbl[k].bsy});
        chk($sformatf("%s c%0d frame_done", tag, cyc), {31'd0, frame_done}, {31'd0, tbl[k].done});
        k++;
      end
    end
    chk($sformatf("%s erase_len", tag), n_er, 5);
    chk($sformatf("%s expose_len", tag), n_ex, 10);
    chk($sformatf("%s convert_len", tag), n_cv, 256);
    chk($sformatf("%s cnt_seq_err", tag), seq_err, 0);
    chk($sformatf("%s phase_excl_err", tag), excl_err, 0);
    chk($sformatf("%s cnt_oe_err", tag), oe_err, 0);
  endtask

  initial begin
    int stall_bad;
    int n_done, done_cyc, late_erase;

    //         cyc   phase     oe    bus    vld   idx   data bsy   done
    tbl[0]  = '{1,   5'b10000, 1'b0, 8'h00, 1'b0, 2'd0, D0,  1'b1, 1'b0};
    tbl[1]  = '{5,   5'b10000, 1'b0, 8'h00, 1'b0, 2'd0, D0,  1'b1, 1'b0};
    tbl[2]  = '{6,   5'b01000, 1'b0, 8'h00, 1'b0, 2'd0, D0,  1'b1, 1'b0};
    tbl[3]  = '{15,  5'b01000, 1'b0, 8'h00, 1'b0, 2'd0, D0,  1'b1, 1'b0};
    tbl[4]  = '{16,  5'b00100, 1'b1, 8'h00, 1'b0, 2'd0, D0,  1'b1, 1'b0};
    tbl[5]  = '{21,  5'b00100, 1'b1, BUS5,  1'b0, 2'd0, D0,  1'b1, 1'b0};
    tbl[6]  = '{271, 5'b00100, 1'b1, BUS255,1'b0, 2'd0, D0,  1'b1, 1'b0};
    tbl[7]  = '{272, 5'b00010, 1'b0, 8'h00, 1'b0, 2'd0, D0,  1'b1, 1'b0};
    tbl[8]  = '{273, 5'b00000, 1'b0, 8'h00, 1'b1, 2'd0, D0,  1'b1, 1'b0};
    tbl[9]  = '{274, 5'b00000, 1'b0, 8'h00, 1'b1, 2'd1, D1,  1'b1, 1'b0};
    tbl[10] = '{275, 5'b00001, 1'b0, 8'h00, 1'b0, 2'd0, D0,  1'b1, 1'b0};
    tbl[11] = '{276, 5'b00000, 1'b0, 8'h00, 1'b1, 2'd2, D2,  1'b1, 1'b0};
    tbl[12] = '{277, 5'b00000, 1'b0, 8'h00, 1'b1, 2'd3, D3,  1'b1, 1'b0};
    tbl[13] = '{278, 5'b00000, 1'b0, 8'h00, 1'b0, 2'd0, D0,  1'b1, 1'b1};
    tbl[14] = '{279, 5'b00000, 1'b0, 8'h00, 1'b0, 2'd0, D0,  1'b0, 1'b0};

    // Reset state
    do_reset();
    chk("reset all_outs", all_outs(), 32'd0);

    // Nominal frame
    run_nominal("nom");

    // Backpressure: hold px_ready low for 20 cycles while idx1 is offered
    do_reset();
    start = 1'b1;
    cyc = 0;
    while (cyc < 274) begin
      step();
      start = 1'b0;
    end
    chk("bp idx1 offered", {px_valid, px_idx}, {1'b1, 2'd1});
    px_ready  = 1'b0;
    stall_bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!px_valid || px_idx !== 2'd1 || px_data !== D1 || read2) stall_bad++;
      step();
    end
    chk("bp stall_hold_err", stall_bad, 0);
    chk("bp still offered", {px_valid, px_idx, px_data}, {1'b1, 2'd1, D1});
    px_ready = 1'b1;
    step();
    chk("bp read2 after xfer", {read2, px_valid}, {1'b1, 1'b0});
    step();
    chk("bp idx2", {px_valid, px_idx, px_data}, {1'b1, 2'd2, D2});
    step();
    step();
    chk("bp frame_done", {29'd0, frame_done, busy}, {29'd0, 1'b1, 1'b1});

    // start pulses mid-frame are ignored
    do_reset();
    start = 1'b1;
    cyc = 0;
    n_done = 0; done_cyc = -1; late_erase = 0;
    for (int c = 1; c <= 300; c++) begin
      step();
      start = (cyc == 50 || cyc == 100);
      if (frame_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (cyc > 279 && (erase || busy)) late_erase++;
    end
    chk("ign done_count", n_done, 1);
    chk("ign done_cycle", done_cyc, 278);
    chk("ign no_second_frame", late_erase, 0);

    // Reset in the middle of conversion
    do_reset();
    start = 1'b1;
    cyc = 0;
    while (cyc < 150) begin
      step();
      start = 1'b0;
    end
    chk("mid convert active", {convert, cnt_oe}, {1'b1, 1'b1});
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("mid reset all_outs", all_outs(), 32'd0);
    step();
    step();
    chk("mid stays idle", {erase, busy}, {1'b0, 1'b0});
    run_nominal("rst");

    // start held high: one IDLE cycle between frames
    do_reset();
    start = 1'b1;
    cyc = 0;
    while (cyc < 278) step();
    chk("b2b done", frame_done, 1'b1);
    step();
    chk("b2b idle gap", {erase, busy}, {1'b0, 1'b0});
    step();
    chk("b2b next erase", {erase, busy}, {1'b1, 1'b1});
    start = 1'b0;
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
